atm_account_engine: RTL and testbench

- Clocked account engine for the ATM: account lookup, PIN authentication, and the transaction functions (balance inquiry, withdraw, deposit, PIN change).
- Holds the balance and PIN databases internally.
- Sequenced by an 8-state FSM.
- Sits under the ATM top, which drives the user inputs and consumes balance/success/state.

---
 rtl/atm_account_engine_if.sv | 26 ++
 rtl/atm_account_engine.sv | 146 ++++++++++++++
 tb/tb_atm_account_engine.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/atm_account_engine_if.sv
// Bus between the ATM top and the account engine: user request inputs and
// the engine's result/status outputs.
interface atm_account_engine_if;
    logic [2:0]  operation;
    logic [3:0]  acc_num;
    logic [15:0] pin;
    logic [15:0] new_pin;
    logic [31:0] amount;
    logic [31:0] balance;
    logic        success;
    logic [2:0]  state;
    logic [3:0]  acc_index;
    logic        acc_found;
    logic        acc_auth;

    // master drives the request (ATM top), slave is the engine
    modport master (
        output operation, acc_num, pin, new_pin, amount,
        input  balance, success, state, acc_index, acc_found, acc_auth
    );

    modport slave (
        input  operation, acc_num, pin, new_pin, amount,
        output balance, success, state, acc_index, acc_found, acc_auth
    );
endinterface

// File: rtl/atm_account_engine.sv
// ATM account engine: account lookup, PIN authentication and the
// balance / deposit / withdraw / PIN-change transactions over internal databases.
module atm_account_engine #(
    parameter int unsigned NUM_ACC  = 10,
    parameter int unsigned BAL_STEP = 1000
) (
    input logic                 clk,
    input logic                 rst,
    atm_account_engine_if.slave bus
);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WAITING    = 3'd1;
    localparam logic [2:0] ST_AUTH       = 3'd2;
    localparam logic [2:0] ST_BALANCE    = 3'd3;
    localparam logic [2:0] ST_DEPOSIT    = 3'd4;
    localparam logic [2:0] ST_WITHDRAW   = 3'd5;
    localparam logic [2:0] ST_CHANGE_PIN = 3'd6;
    localparam logic [2:0] ST_MENU       = 3'd7;

    localparam logic [4:0] NUM_ACC_W = 5'(NUM_ACC);

    logic [2:0]  state_q, state_nxt;
    logic [3:0]  idx_q, idx_nxt;
    logic [31:0] bal_q, bal_nxt;
    logic        succ_q, succ_nxt;

    logic [31:0] balance_db [16];
    logic [15:0] pin_db     [16];

    logic        bal_we;
    logic [31:0] bal_wdata;
    logic        pin_we;
    logic [31:0] cur_bal;
    logic [32:0] dep_sum;
    logic        found;
    logic        auth;

    assign cur_bal = balance_db[idx_q];
    assign dep_sum = {1'b0, cur_bal} + {1'b0, bus.amount};
    assign found   = ({1'b0, bus.acc_num} < NUM_ACC_W);
    assign auth    = (bus.pin == pin_db[idx_q]);

    always_comb begin
        state_nxt = state_q;
        idx_nxt   = idx_q;
        succ_nxt  = succ_q;
        bal_we    = 1'b0;
        bal_wdata = cur_bal;
        pin_we    = 1'b0;

        case (state_q)
            ST_IDLE: state_nxt = ST_WAITING;

            ST_WAITING: begin
                if (found) begin
                    idx_nxt   = bus.acc_num;
                    state_nxt = ST_AUTH;
                end
            end

            ST_AUTH: begin
                succ_nxt  = 1'b0;
                state_nxt = auth ? ST_MENU : ST_WAITING;
            end

            ST_MENU: begin
                case (bus.operation)
                    3'd3:    state_nxt = ST_BALANCE;
                    3'd4:    state_nxt = ST_DEPOSIT;
                    3'd5:    state_nxt = ST_WITHDRAW;
                    3'd6:    state_nxt = ST_CHANGE_PIN;
                    default: state_nxt = ST_MENU;
                endcase
            end

            ST_BALANCE: begin
                succ_nxt  = 1'b1;
                state_nxt = ST_WAITING;
            end

            ST_DEPOSIT: begin
                // carry out of the 33-bit sum means the balance would wrap
                if (dep_sum[32]) begin
                    succ_nxt = 1'b0;
                end else begin
                    bal_we    = 1'b1;
                    bal_wdata = dep_sum[31:0];
                    succ_nxt  = 1'b1;
                end
                state_nxt = ST_WAITING;
            end

            ST_WITHDRAW: begin
                if (bus.amount <= cur_bal) begin
                    bal_we    = 1'b1;
                    bal_wdata = cur_bal - bus.amount;
                    succ_nxt  = 1'b1;
                end else begin
                    succ_nxt = 1'b0;
                end
                state_nxt = ST_WAITING;
            end

            ST_CHANGE_PIN: begin
                pin_we    = 1'b1;
                succ_nxt  = 1'b1;
                state_nxt = ST_WAITING;
            end

            default: state_nxt = ST_IDLE;
        endcase

        // writes only occur in action states, where idx_nxt == idx_q,
        // so forwarding the write data gives the same-edge post-update value
        bal_nxt = bal_we ? bal_wdata : balance_db[idx_nxt];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            bal_q   <= '0;
            succ_q  <= 1'b0;
            for (int unsigned i = 0; i < 16; i++) begin
                balance_db[i] <= 32'(BAL_STEP * (i + 1));
                pin_db[i]     <= {4{i[3:0]}};
            end
        end else begin
            state_q <= state_nxt;
            idx_q   <= idx_nxt;
            bal_q   <= bal_nxt;
            succ_q  <= succ_nxt;
            if (bal_we) balance_db[idx_q] <= bal_wdata;
            if (pin_we) pin_db[idx_q]     <= bus.new_pin;
        end
    end

    assign bus.state     = state_q;
    assign bus.acc_index = idx_q;
    assign bus.balance   = bal_q;
    assign bus.success   = succ_q;
    assign bus.acc_found = found;
    assign bus.acc_auth  = auth;

endmodule

// File: tb/tb_atm_account_engine.sv
// Randomized self-checking bench for atm_account_engine against a
// transaction-level model of the account databases.
module tb_atm_account_engine;

    localparam int NUM_ACC  = 10;
    localparam int BAL_STEP = 1000;

    logic clk = 1'b0;
    logic rst = 1'b0;

    atm_account_engine_if bus ();

    atm_account_engine #(.NUM_ACC(NUM_ACC), .BAL_STEP(BAL_STEP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_bal [16];
    logic [15:0] m_pin [16];
    logic        m_succ;
    int          cur;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_bal[i] = 32'(BAL_STEP * (i + 1));
            m_pin[i] = {4{4'(i)}};
        end
        m_succ = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts in WAITING; leaves the engine in MENU (in_menu=1) or WAITING.
    task automatic login(input int acc, input logic [15:0] p, output bit in_menu);
        in_menu = 0;
        bus.acc_num   = 4'(acc);
        bus.operation = 3'($urandom);
        #1;
        chk("acc_found", 32'(bus.acc_found), 32'(acc < NUM_ACC));
        step();
        if (acc >= NUM_ACC) begin
            chk("wait_stay", 32'(bus.state), 32'd1);
            return;
        end
        cur = acc;
        chk("auth_state", 32'(bus.state), 32'd2);
        chk("acc_index", 32'(bus.acc_index), 32'(acc));
        chk("auth_bal", bus.balance, m_bal[acc]);
        bus.pin     = p;
        bus.acc_num = 4'($urandom);
        #1;
        chk("acc_auth", 32'(bus.acc_auth), 32'(p == m_pin[acc]));
        step();
        m_succ = 1'b0;
        chk("auth_succ", 32'(bus.success), 32'd0);
        if (p == m_pin[acc]) begin
            chk("menu_state", 32'(bus.state), 32'd7);
            in_menu = 1;
        end else begin
            chk("reject_state", 32'(bus.state), 32'd1);
        end
    endtask

    // Starts in MENU; a non-transaction code keeps it in MENU.
    task automatic do_op(input logic [2:0] op, input logic [31:0] amt, input logic [15:0] np);
        longint unsigned sum;
        bus.operation = op;
        bus.amount    = $urandom;
        bus.new_pin   = 16'($urandom);
        step();
        if (op < 3'd3 || op > 3'd6) begin
            chk("menu_hold", 32'(bus.state), 32'd7);
            chk("menu_succ", 32'(bus.success), 32'(m_succ));
            return;
        end
        chk("action_state", 32'(bus.state), 32'(op));
        chk("action_bal", bus.balance, m_bal[cur]);
        bus.amount    = amt;
        bus.new_pin   = np;
        bus.operation = 3'($urandom);
        step();
        case (op)
            3'd3: m_succ = 1'b1;
            3'd4: begin
                sum = 64'(m_bal[cur]) + 64'(amt);
                if (sum > 64'hFFFF_FFFF) m_succ = 1'b0;
                else begin
                    m_bal[cur] = 32'(sum);
                    m_succ = 1'b1;
                end
            end
            3'd5: begin
                if (amt <= m_bal[cur]) begin
                    m_bal[cur] = m_bal[cur] - amt;
                    m_succ = 1'b1;
                end else m_succ = 1'b0;
            end
            default: begin
                m_pin[cur] = np;
                m_succ = 1'b1;
            end
        endcase
        chk("post_state", 32'(bus.state), 32'd1);
        chk("post_bal", bus.balance, m_bal[cur]);
        chk("post_succ", 32'(bus.success), 32'(m_succ));
    endtask

    function automatic logic [31:0] pick_amt(input logic [31:0] bal);
        case ($urandom_range(0, 4))
            0: return (bal == 0) ? 32'd0 : 32'($urandom_range(0, bal));
            1: return bal;
            2: return bal + 32'd1;
            3: return 32'd0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int acc;
        logic [15:0] p;
        logic [2:0] op;

        bus.operation = '0;
        bus.acc_num   = '0;
        bus.pin       = '0;
        bus.new_pin   = '0;
        bus.amount    = '0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_index", 32'(bus.acc_index), 32'd0);
        chk("rst_bal", bus.balance, 32'd0);
        chk("rst_succ", 32'(bus.success), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("idle_exit", 32'(bus.state), 32'd1);

        // directed scenarios
        login(2, 16'h2222, ok);
        chk("login2", 32'(ok), 32'd1);
        do_op(3'd3, 32'd0, 16'd0);
        chk("bal2", bus.balance, 32'd3000);
        login(2, 16'h2222, ok);
        do_op(3'd5, 32'd500, 16'd0);
        chk("wd500", bus.balance, 32'd2500);
        login(2, 16'h2222, ok);
        do_op(3'd5, 32'd5000, 16'd0);
        chk("wd5000_fail", 32'(bus.success), 32'd0);
        login(0, 16'h0000, ok);
        do_op(3'd4, 32'd700, 16'd0);
        chk("dep700", bus.balance, 32'd1700);
        login(0, 16'h0000, ok);
        do_op(3'd4, 32'hFFFF_FFFF, 16'd0);
        chk("dep_ovf", bus.balance, 32'd1700);
        login(4, 16'h1234, ok);
        chk("bad_pin", 32'(ok), 32'd0);
        login(5, 16'h5555, ok);
        do_op(3'd6, 32'd0, 16'hBEEF);
        login(5, 16'h5555, ok);
        chk("old_pin", 32'(ok), 32'd0);
        login(5, 16'hBEEF, ok);
        chk("new_pin", 32'(ok), 32'd1);
        do_op(3'd0, 32'd0, 16'd0);
        do_op(3'd3, 32'd0, 16'd0);
        login(12, 16'h0000, ok);

        // randomized sessions
        for (int n = 0; n < 120; n++) begin
            acc = $urandom_range(0, 11);
            if ($urandom_range(0, 3) != 0) p = m_pin[acc];
            else p = m_pin[acc] ^ 16'($urandom_range(1, 65535));
            login(acc, p, ok);
            if (ok) begin
                if ($urandom_range(0, 4) == 0) begin
                    op = 3'($urandom_range(0, 2));
                    if ($urandom_range(0, 1) == 1) op = 3'd7;
                    do_op(op, 32'd0, 16'd0);
                end
                op = 3'($urandom_range(3, 6));
                do_op(op, pick_amt(m_bal[acc]), 16'($urandom));
            end
        end

        // reset while sitting in MENU after a withdraw
        login(2, m_pin[2], ok);
        do_op(3'd5, 32'd0, 16'd0);
        login(2, m_pin[2], ok);
        chk("pre_rst_menu", 32'(bus.state), 32'd7);
        #3 rst = 1'b0;
        #1;
        chk("async_state", 32'(bus.state), 32'd0);
        chk("async_bal", bus.balance, 32'd0);
        chk("async_succ", 32'(bus.success), 32'd0);
        chk("async_index", 32'(bus.acc_index), 32'd0);
        #2 rst = 1'b1;
        model_reset();
        step();
        chk("rst2_wait", 32'(bus.state), 32'd1);
        login(2, 16'h2222, ok);
        chk("restored_pin2", 32'(ok), 32'd1);
        do_op(3'd3, 32'd0, 16'd0);
        chk("restored_bal2", bus.balance, 32'd3000);
        login(5, 16'h5555, ok);
        chk("restored_pin5", 32'(ok), 32'd1);
        do_op(3'd3, 32'd0, 16'd0);
        chk("restored_bal5", bus.balance, 32'd6000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
